spi_xfer_controller: RTL and testbench
======================================

// Module: spi_xfer_controller
// PURPOSE
//  Transaction sequencer for the SPI memory slave. Counts conditioned SCLK edges
//  within a CS-low frame, decodes the address/RW byte, and drives the strobes that
//  sequence the shift register, address latch, data memory and MISO output buffer.
//  Frame: 7-bit address (MSB first), R/W bit (1 = read), then 8 data bits.
// PARAMETERS
//  ADDR_WIDTH  7  memory address bits; the header byte is ADDR_WIDTH+1 bits
//  DATA_WIDTH  8  data bits per transfer
//  CNT_WIDTH   4  width of bit counter; must hold max(ADDR_WIDTH+1, DATA_WIDTH)
// PORTS
//  clk            in   1  FPGA system clock; all state changes on posedge
//  reset          in   1  asynchronous, active-low reset
//  cs             in   1  conditioned chip select, active-low
//  sclk_posedge   in   1  one-clk pulse per rising SCLK edge, from the input conditioner
//  mosi           in   1  conditioned MOSI level
//  addr_latch_we  out  1  one-clk strobe: address latch captures shift register bits
//  sr_load        out  1  one-clk strobe: shift register parallel-loads memory output
//  mem_we         out  1  one-clk strobe: data memory writes shift register contents
//  miso_oe        out  1  MISO buffer enable; high only while read data shifts out
//  busy           out  1  high in any state except IDLE
//  xfer_done      out  1  one-clk pulse when a frame completes normally
//  overrun        out  1  sticky: SCLK edge arrived while a strobe state was in progress
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, counter=0, rw_q=0; all outputs 0.
//  All outputs are registered and decoded from the state register.
//  States and transitions (cs=1 in any non-IDLE state -> IDLE next clk; this abort
//  has priority over every other transition, and aborts never assert mem_we or xfer_done):
//   IDLE       : cs=0 -> GET_HDR; counter<=0; overrun<=0.
//   GET_HDR    : each sclk_posedge increments counter. On the posedge that makes
//                counter=ADDR_WIDTH+1: rw_q<=mosi; -> LATCH_ADDR.
//   LATCH_ADDR : addr_latch_we=1 for exactly this clk; counter<=0;
//                -> READ_WAIT if rw_q=1, else WRITE_GET.
//   READ_WAIT  : one clk for the memory read to settle at the new address; -> READ_LOAD.
//   READ_LOAD  : sr_load=1 for exactly this clk; -> READ_SHIFT.
//   READ_SHIFT : miso_oe=1; count sclk_posedge; at counter=DATA_WIDTH -> DONE.
//   WRITE_GET  : count sclk_posedge; at counter=DATA_WIDTH -> WRITE_MEM.
//   WRITE_MEM  : mem_we=1 for exactly this clk; -> DONE.
//   DONE       : xfer_done=1 on the first clk only. Extra sclk_posedge ignored.
//                Stays here until cs=1, then -> IDLE.
//  Latency: addr_latch_we is asserted 1 clk after the header's final sclk_posedge.
//  On read, sr_load is asserted 3 clk after that posedge. mem_we is asserted 1 clk
//  after the 8th data posedge.
//  Timing requirement: SCLK period >= 8 clk. An sclk_posedge during LATCH_ADDR,
//  READ_WAIT, READ_LOAD or WRITE_MEM sets overrun=1, is not counted, and the
//  sequence continues. overrun clears only on reset or the IDLE->GET_HDR transition.
//  Counter saturates at its terminal value and never wraps within a frame.
//  A cs rise in the same clk as a terminal sclk_posedge is an abort: the FSM goes
//  to IDLE, with no LATCH_ADDR and no WRITE_MEM.
//  Reset asserted mid-frame: outputs 0 immediately (asynchronous), with no partial
//  strobe. After release, the FSM stays in IDLE until it sees cs=0; if cs is still
//  low at release, a new frame starts with counter=0.
// TESTING
//  1 Write: cs=0, header 0x2A<<1|0 (addr 0x2A, W), data 0xA5, cs=1 -> one addr_latch_we
//    1 clk after posedge 8; one mem_we 1 clk after posedge 16; xfer_done pulse; miso_oe=0.
//  2 Read: header 0x2A<<1|1 -> addr_latch_we, then sr_load 3 clk after posedge 8;
//    miso_oe=1 for posedges 9..16; one xfer_done; mem_we never asserted.
//  3 Abort: cs=1 after 5 header posedges -> IDLE next clk; no strobe ever; busy=0.
//  4 Write abort race: cs rises in the same clk as data posedge 8 -> no mem_we,
//    no xfer_done; the next frame works normally.
//  5 Overrun: issue an sclk_posedge during READ_WAIT -> overrun=1 and remains set;
//    overrun clears on the next cs fall.
//  6 Reset: pull reset low during WRITE_GET -> all outputs 0 within the same clk;
//    after release with cs=1, stays in IDLE; a new write frame completes correctly.

Source files
------------

// File: rtl/spi_xfer_controller.sv
// SPI memory slave transaction sequencer.
// Counts SCLK edges per CS frame and drives the datapath strobes.
module spi_xfer_controller #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_posedge,
  input  logic mosi,
  output logic addr_latch_we,
  output logic sr_load,
  output logic mem_we,
  output logic miso_oe,
  output logic busy,
  output logic xfer_done,
  output logic overrun
);

  typedef enum logic [3:0] {
    IDLE,
    GET_HDR,
    LATCH_ADDR,
    READ_WAIT,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_MEM,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HDR_LAST =
    CNT_WIDTH'(ADDR_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] DAT_LAST =
    CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic rw_q, rw_n;
  logic ovr_n;
  logic strobe_st;
  logic lat_n, ld_n, mw_n, oe_n, busy_n, done_n;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  assign strobe_st = state inside
    {LATCH_ADDR, READ_WAIT, READ_LOAD, WRITE_MEM};

  // State, bit counter, R/W flag and sticky overrun registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rw_q    <= rw_n;
      overrun <= ovr_n;
    end
  end

  // Next-state logic; a CS rise beats every other transition
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rw_n    = rw_q;
    ovr_n   = overrun;
    if (sclk_posedge && strobe_st) ovr_n = 1'b1;
    if (state != IDLE && cs) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cs) begin
            state_n = GET_HDR;
            cnt_n   = '0;
            ovr_n   = 1'b0;
          end
        end
        GET_HDR: begin
          if (sclk_posedge) begin
            cnt_n = cnt_inc;
            if (cnt_inc == HDR_LAST) begin
              rw_n    = mosi;
              state_n = LATCH_ADDR;
            end
          end
        end
        LATCH_ADDR: begin
          cnt_n   = '0;
          state_n = rw_q ? READ_WAIT : WRITE_GET;
        end
        READ_WAIT: state_n = READ_LOAD;
        READ_LOAD: state_n = READ_SHIFT;
        READ_SHIFT, WRITE_GET: begin
          if (sclk_posedge) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DAT_LAST)
              state_n = (state == READ_SHIFT) ? DONE : WRITE_MEM;
          end
        end
        WRITE_MEM: state_n = DONE;
        DONE:      state_n = DONE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so strobes are flop outputs
  always_comb begin
    lat_n  = (state_n == LATCH_ADDR);
    ld_n   = (state_n == READ_LOAD);
    mw_n   = (state_n == WRITE_MEM);
    oe_n   = (state_n == READ_SHIFT);
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE) && (state != DONE);
  end

  // Registered strobes, cleared at once by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_latch_we <= 1'b0;
      sr_load       <= 1'b0;
      mem_we        <= 1'b0;
      miso_oe       <= 1'b0;
      busy          <= 1'b0;
      xfer_done     <= 1'b0;
    end else begin
      addr_latch_we <= lat_n;
      sr_load       <= ld_n;
      mem_we        <= mw_n;
      miso_oe       <= oe_n;
      busy          <= busy_n;
      xfer_done     <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_xfer_controller.sv
// Bench for spi_xfer_controller.
// Frames are planned up front as per-cycle tables with expected outputs.
module tb_spi_xfer_controller;

  localparam int N = 12000;
  localparam int M_OVR  = 0;
  localparam int M_OE   = 1;
  localparam int M_BUSY = 2;
  localparam int M_CS   = 3;

  logic clk = 1'b0;
  logic reset, cs, sclk_posedge, mosi;
  logic addr_latch_we, sr_load, mem_we, miso_oe;
  logic busy, xfer_done, overrun;

  bit cs_a[N], sp_a[N], mo_a[N], rn_a[N];
  bit e_lat[N], e_ld[N], e_mw[N], e_oe[N];
  bit e_busy[N], e_done[N], e_ovr[N];

  int wp;
  int ncyc;
  int checks = 0;
  int errors = 0;

  spi_xfer_controller dut (
    .clk           (clk),
    .reset         (reset),
    .cs            (cs),
    .sclk_posedge  (sclk_posedge),
    .mosi          (mosi),
    .addr_latch_we (addr_latch_we),
    .sr_load       (sr_load),
    .mem_we        (mem_we),
    .miso_oe       (miso_oe),
    .busy          (busy),
    .xfer_done     (xfer_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  function automatic int gap(input bit fx);
    return fx ? 8 : int'($urandom_range(8, 12));
  endfunction

  task automatic mark(input int sel, input int a,
                      input int b, input bit v);
    for (int j = a; j <= b && j < N; j++) begin
      case (sel)
        M_OVR:   e_ovr[j]  = v;
        M_OE:    e_oe[j]   = v;
        M_BUSY:  e_busy[j] = v;
        default: cs_a[j]   = v;
      endcase
    end
  endtask

  // Frame ends with CS high at cycle e: busy runs f+1..e
  task automatic close(input int f, input int e, input bit fx);
    mark(M_CS, f, e - 1, 1'b0);
    mark(M_BUSY, f + 1, e, 1'b1);
    wp = e + (fx ? 3 : int'($urandom_range(2, 5)));
  endtask

  // kind: 0 normal, 1 header abort after nab edges,
  // 2 cs rise on 8th header edge, 3 cs rise on 8th data edge,
  // 4 reset after 4th data edge (nab=1 keeps cs low)
  // spot: 1..3 stray edge at h+spot, 4 stray edge during mem write
  task automatic frame(input bit rw, input logic [6:0] addr,
                       input logic [7:0] data, input int kind,
                       input int nab, input int spot, input bit fx);
    logic [7:0] hdr;
    int f, k, h, d, dn, e, r, len;
    hdr = {addr, rw};
    f = wp;
    mark(M_OVR, f + 1, N - 1, 1'b0);
    k = f + (fx ? 2 : int'($urandom_range(1, 4)));
    for (int i = 0; i < 8; i++) begin
      if (kind == 1 && i == nab) begin
        close(f, k, fx);
        return;
      end
      sp_a[k] = 1'b1;
      mo_a[k] = hdr[7-i];
      if (kind == 2 && i == 7) begin
        close(f, k, fx);
        return;
      end
      if (i < 7) k += gap(fx);
    end
    h = k;
    e_lat[h+1] = 1'b1;
    if (spot >= 1 && spot <= 3) begin
      sp_a[h+spot] = 1'b1;
      mark(M_OVR, h + spot + 1, N - 1, 1'b1);
    end
    if (rw) e_ld[h+3] = 1'b1;
    k = h + gap(fx);
    for (int i = 0; i < 8; i++) begin
      sp_a[k] = 1'b1;
      mo_a[k] = data[7-i];
      if (kind == 4 && i == 3) begin
        r = k + 2;
        len = int'($urandom_range(2, 4));
        for (int j = r; j < r + len; j++) rn_a[j] = 1'b0;
        mark(M_OVR, r, N - 1, 1'b0);
        if (rw) mark(M_OE, h + 4, r - 1, 1'b1);
        mark(M_BUSY, f + 1, r - 1, 1'b1);
        if (nab != 0) begin
          mark(M_CS, f, r + len - 1, 1'b0);
          wp = r + len;
        end else begin
          mark(M_CS, f, r - 1, 1'b0);
          wp = r + len + int'($urandom_range(2, 5));
        end
        return;
      end
      if (i < 7) k += gap(fx);
    end
    d = k;
    if (rw) mark(M_OE, h + 4, d, 1'b1);
    if (kind == 3) begin
      close(f, d, fx);
      return;
    end
    if (rw) begin
      dn = d + 1;
    end else begin
      dn = d + 2;
      e_mw[d+1] = 1'b1;
      if (spot == 4) begin
        sp_a[d+1] = 1'b1;
        mark(M_OVR, d + 2, N - 1, 1'b1);
      end
    end
    e_done[dn] = 1'b1;
    k = dn;
    if (!fx) begin
      repeat (int'($urandom_range(0, 2))) begin
        k += gap(1'b0);
        sp_a[k] = 1'b1;
      end
    end
    e = k + (fx ? 4 : int'($urandom_range(2, 6)));
    close(f, e, fx);
  endtask

  task automatic chk(input string nm, input int k,
                     input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s cyc=%0d got=%0b exp=%0b",
                 nm, k, act, exp);
    end
  endtask

  task automatic build();
    int kind, spot, nab;
    bit rw;
    for (int j = 0; j < N; j++) begin
      cs_a[j] = 1'b1;
      rn_a[j] = 1'b1;
    end
    for (int j = 0; j < 4; j++) rn_a[j] = 1'b0;
    wp = 10;
    frame(1'b0, 7'h2A, 8'hA5, 0, 0, 0, 1'b1);
    frame(1'b1, 7'h2A, 8'h3C, 0, 0, 0, 1'b1);
    frame(1'b0, 7'h11, 8'h00, 1, 5, 0, 1'b0);
    frame(1'b0, 7'h55, 8'hFF, 3, 0, 0, 1'b0);
    frame(1'b0, 7'h33, 8'h5A, 0, 0, 0, 1'b0);
    frame(1'b1, 7'h7F, 8'h00, 2, 0, 0, 1'b0);
    frame(1'b1, 7'h01, 8'h00, 0, 0, 2, 1'b0);
    frame(1'b0, 7'h02, 8'hC3, 0, 0, 0, 1'b0);
    frame(1'b0, 7'h40, 8'h81, 4, 0, 0, 1'b0);
    frame(1'b0, 7'h41, 8'h7E, 0, 0, 0, 1'b0);
    frame(1'b0, 7'h42, 8'h18, 4, 1, 0, 1'b0);
    frame(1'b1, 7'h43, 8'h00, 0, 0, 0, 1'b0);
    while (wp < N - 400) begin
      rw   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      if (kind == 5) kind = 0;
      nab  = 0;
      if (kind == 1) nab = int'($urandom_range(1, 7));
      if (kind == 4) nab = int'($urandom_range(0, 1));
      if (rw) spot = int'($urandom_range(0, 3));
      else begin
        case ($urandom_range(0, 2))
          0:       spot = 0;
          1:       spot = 1;
          default: spot = 4;
        endcase
      end
      frame(rw, 7'($urandom), 8'($urandom), kind, nab, spot, 1'b0);
    end
    frame(1'b0, 7'h0F, 8'hF0, 0, 0, 0, 1'b0);
    ncyc = wp + 5;
  endtask

  initial begin
    reset = 1'b0;
    cs = 1'b1;
    sclk_posedge = 1'b0;
    mosi = 1'b0;
    build();
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      reset        = rn_a[k];
      cs           = cs_a[k];
      sclk_posedge = sp_a[k];
      mosi         = mo_a[k];
      @(negedge clk);
      chk("addr_latch_we", k, addr_latch_we, e_lat[k]);
      chk("sr_load", k, sr_load, e_ld[k]);
      chk("mem_we", k, mem_we, e_mw[k]);
      chk("miso_oe", k, miso_oe, e_oe[k]);
      chk("busy", k, busy, e_busy[k]);
      chk("xfer_done", k, xfer_done, e_done[k]);
      chk("overrun", k, overrun, e_ovr[k]);
      if (k == 2)   chk("pin_reset_busy", k, busy, 1'b0);
      if (k == 10)  chk("pin_idle_busy", k, busy, 1'b0);
      if (k == 11)  chk("pin_start_busy", k, busy, 1'b1);
      if (k == 68)  chk("pin_latch_early", k, addr_latch_we, 1'b0);
      if (k == 69)  chk("pin_latch", k, addr_latch_we, 1'b1);
      if (k == 133) chk("pin_mem_we", k, mem_we, 1'b1);
      if (k == 134) chk("pin_wr_done", k, xfer_done, 1'b1);
      if (k == 139) chk("pin_wr_idle", k, busy, 1'b0);
      if (k == 200) chk("pin_rd_latch", k, addr_latch_we, 1'b1);
      if (k == 202) chk("pin_sr_load", k, sr_load, 1'b1);
      if (k == 203) chk("pin_oe_on", k, miso_oe, 1'b1);
      if (k == 264) chk("pin_rd_done", k, xfer_done, 1'b1);
      if (k == 264) chk("pin_oe_off", k, miso_oe, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
